// File: rtl/bus_driver_mux.sv
// Registered N-source bus multiplexer with priority selection and contention tracking.
// One-cycle latency; every output comes straight from a flop.
module bus_driver_mux #(
    parameter int WIDTH     = 32,
    parameter int N         = 32,
    parameter int SELW      = $clog2(N),
    parameter int PRIO_LOW  = 1,
    parameter int HOLD_LAST = 1
) (
    input  logic                 clock,
    input  logic                 clear,
    input  logic [N-1:0]         src_en,
    input  logic [N*WIDTH-1:0]   src_data,
    input  logic                 clr_err,
    output logic [WIDTH-1:0]     bus_out,
    output logic                 bus_valid,
    output logic [SELW-1:0]      bus_sel,
    output logic                 contention,
    output logic                 contention_sticky,
    output logic [7:0]           contention_count
);

    logic [SELW-1:0]  winner;
    logic             any_req;
    logic             multi_req;
    logic [WIDTH-1:0] winner_word;
    logic [7:0]       count_next;
    logic             sticky_next;

    // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        winner    = '0;
        any_req   = 1'b0;
        multi_req = 1'b0;
        // Scan so that the preferred index is the last one written.
        if (PRIO_LOW != 0) begin
            for (int i = N - 1; i >= 0; i--) begin
                if (src_en[i]) winner = SELW'(i);
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (src_en[i]) winner = SELW'(i);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (src_en[i]) begin
                multi_req = multi_req | any_req;
                any_req   = 1'b1;
            end
        end
    end

    assign winner_word = src_data[int'(winner) * WIDTH +: WIDTH];

    // Contention in the same cycle as clr_err wins: the clear restarts the count at one.
    always_comb begin
        count_next  = contention_count;
        sticky_next = contention_sticky;
        if (multi_req) begin
            sticky_next = 1'b1;
            if (clr_err)
                count_next = 8'd1;
            else if (contention_count != 8'hFF)
                count_next = contention_count + 8'd1;
        end else if (clr_err) begin
            sticky_next = 1'b0;
            count_next  = 8'd0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clock) begin
        if (clear) begin
            bus_out           <= '0;
            bus_valid         <= 1'b0;
            bus_sel           <= '0;
            contention        <= 1'b0;
            contention_sticky <= 1'b0;
            contention_count  <= 8'd0;
        end else begin
            bus_valid         <= any_req;
            contention        <= multi_req;
            contention_sticky <= sticky_next;
            contention_count  <= count_next;
            if (any_req) begin
                bus_out <= winner_word;
                bus_sel <= winner;
            end else if (HOLD_LAST == 0) begin
                bus_out <= '0;
            end
        end
    end

endmodule

// File: tb/tb_bus_driver_mux.sv
// Directed bench for bus_driver_mux: two 32x32 instances with opposite priority/hold
// settings share stimulus; two 5x8 instances cover the small-N selection.
module tb_bus_driver_mux;

    logic         clock = 1'b0;
    logic         clear;
    logic         clr_err;
    logic [31:0]  en32;
    logic [1023:0] data32;
    logic [4:0]   en5;
    logic [39:0]  data5;

    logic [31:0] out_a, out_b;
    logic        valid_a, valid_b, cont_a, cont_b, sticky_a, sticky_b;
    logic [4:0]  sel_a, sel_b;
    logic [7:0]  cnt_a, cnt_b;

    logic [7:0]  out_c, out_d;
    logic        valid_c, valid_d, cont_c, cont_d, sticky_c, sticky_d;
    logic [2:0]  sel_c, sel_d;
    logic [7:0]  cnt_c, cnt_d;

    int n_vec = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    bus_driver_mux #(.WIDTH(32), .N(32), .PRIO_LOW(1), .HOLD_LAST(1)) u_a (
        .clock(clock), .clear(clear), .src_en(en32), .src_data(data32), .clr_err(clr_err),
        .bus_out(out_a), .bus_valid(valid_a), .bus_sel(sel_a), .contention(cont_a),
        .contention_sticky(sticky_a), .contention_count(cnt_a));

    bus_driver_mux #(.WIDTH(32), .N(32), .PRIO_LOW(0), .HOLD_LAST(0)) u_b (
        .clock(clock), .clear(clear), .src_en(en32), .src_data(data32), .clr_err(clr_err),
        .bus_out(out_b), .bus_valid(valid_b), .bus_sel(sel_b), .contention(cont_b),
        .contention_sticky(sticky_b), .contention_count(cnt_b));

    bus_driver_mux #(.WIDTH(8), .N(5), .PRIO_LOW(1)) u_c (
        .clock(clock), .clear(clear), .src_en(en5), .src_data(data5), .clr_err(clr_err),
        .bus_out(out_c), .bus_valid(valid_c), .bus_sel(sel_c), .contention(cont_c),
        .contention_sticky(sticky_c), .contention_count(cnt_c));

    bus_driver_mux #(.WIDTH(8), .N(5), .PRIO_LOW(0)) u_d (
        .clock(clock), .clear(clear), .src_en(en5), .src_data(data5), .clr_err(clr_err),
        .bus_out(out_d), .bus_valid(valid_d), .bus_sel(sel_d), .contention(cont_d),
        .contention_sticky(sticky_d), .contention_count(cnt_d));

    typedef struct {
        logic        clear;
        logic        clr_err;
        logic [31:0] en;
        logic [4:0]  sel_a;
        logic [31:0] out_a;
        logic [4:0]  sel_b;
        logic [31:0] out_b;
        logic        valid;
        logic        cont;
        logic        sticky;
        logic [7:0]  cnt;
    } vec_t;

    vec_t vt[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_big(input string tag, input logic [4:0] xsa, input logic [31:0] xoa,
                             input logic [4:0] xsb, input logic [31:0] xob, input logic xv,
                             input logic xc, input logic xs, input logic [7:0] xn);
        n_vec++;
        check({tag, " a.sel"},    32'(sel_a),    32'(xsa));
        check({tag, " a.out"},    out_a,         xoa);
        check({tag, " a.valid"},  32'(valid_a),  32'(xv));
        check({tag, " a.cont"},   32'(cont_a),   32'(xc));
        check({tag, " a.sticky"}, 32'(sticky_a), 32'(xs));
        check({tag, " a.cnt"},    32'(cnt_a),    32'(xn));
        check({tag, " b.sel"},    32'(sel_b),    32'(xsb));
        check({tag, " b.out"},    out_b,         xob);
        check({tag, " b.valid"},  32'(valid_b),  32'(xv));
        check({tag, " b.cont"},   32'(cont_b),   32'(xc));
        check({tag, " b.sticky"}, 32'(sticky_b), 32'(xs));
        check({tag, " b.cnt"},    32'(cnt_b),    32'(xn));
    endtask

    initial begin
        logic [7:0] small_exp [5];

        // Slice i = 0x1220+i, except slice 7 = DEADBEEF and slice 31 = FFFFFFFF.
        for (int i = 0; i < 32; i++)
            data32[i*32 +: 32] = (i == 31) ? 32'hFFFF_FFFF :
                                 (i == 7)  ? 32'hDEAD_BEEF : 32'(32'h1220 + i);
        for (int i = 0; i < 5; i++) data5[i*8 +: 8] = 8'(8'h11 * (i + 1));
        small_exp = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

        //        clr clre en            sA  outA          sB  outB          v  c  s  cnt
        vt[0]  = '{1, 0, 32'h0000_0000,  0, 32'h0,        0, 32'h0,        0, 0, 0, 0};
        vt[1]  = '{0, 0, 32'h0010_0000, 20, 32'h1234,    20, 32'h1234,     1, 0, 0, 0};
        vt[2]  = '{0, 0, 32'h0002_0008,  3, 32'h1223,    17, 32'h1231,     1, 1, 1, 1};
        vt[3]  = '{0, 0, 32'h0000_0080,  7, 32'hDEADBEEF, 7, 32'hDEADBEEF, 1, 0, 1, 1};
        vt[4]  = '{0, 0, 32'h0000_0000,  7, 32'hDEADBEEF, 7, 32'h0,        0, 0, 1, 1};
        vt[5]  = '{0, 0, 32'h0000_0000,  7, 32'hDEADBEEF, 7, 32'h0,        0, 0, 1, 1};
        vt[6]  = '{0, 0, 32'hFFFF_FFFF,  0, 32'h1220,    31, 32'hFFFFFFFF, 1, 1, 1, 2};
        vt[7]  = '{0, 1, 32'h0000_0001,  0, 32'h1220,     0, 32'h1220,     1, 0, 0, 0};
        vt[8]  = '{0, 1, 32'h4000_0002,  1, 32'h1221,    30, 32'h123E,     1, 1, 1, 1};
        vt[9]  = '{1, 0, 32'h8000_0000,  0, 32'h0,        0, 32'h0,        0, 0, 0, 0};
        vt[10] = '{0, 0, 32'h8000_0000, 31, 32'hFFFFFFFF,31, 32'hFFFFFFFF, 1, 0, 0, 0};
        vt[11] = '{0, 0, 32'h0000_0260,  5, 32'h1225,     9, 32'h1229,     1, 1, 1, 1};
        vt[12] = '{1, 1, 32'h0000_0003,  0, 32'h0,        0, 32'h0,        0, 0, 0, 0};

        clear = 1'b1; clr_err = 1'b0; en32 = '0; en5 = '0;
        tick();
        clear = 1'b0;
        tick();

        for (int v = 0; v < 13; v++) begin
            clear   = vt[v].clear;
            clr_err = vt[v].clr_err;
            en32    = vt[v].en;
            tick();
            check_big($sformatf("vec%0d", v), vt[v].sel_a, vt[v].out_a, vt[v].sel_b,
                      vt[v].out_b, vt[v].valid, vt[v].cont, vt[v].sticky, vt[v].cnt);
        end

        // Saturation: 300 back-to-back contention cycles.
        clear = 1'b0; clr_err = 1'b0; en32 = 32'h3;
        for (int k = 0; k < 255; k++) tick();
        check_big("sat255", 0, 32'h1220, 1, 32'h1221, 1, 1, 1, 8'd255);
        for (int k = 0; k < 45; k++) tick();
        check_big("sat300", 0, 32'h1220, 1, 32'h1221, 1, 1, 1, 8'd255);

        clr_err = 1'b1; en32 = 32'h1;
        tick();
        check_big("clr_noconf", 0, 32'h1220, 0, 32'h1220, 1, 0, 0, 8'd0);

        clr_err = 1'b1; en32 = 32'h3;
        tick();
        check_big("clr_conf", 0, 32'h1220, 1, 32'h1221, 1, 1, 1, 8'd1);
        clr_err = 1'b0; en32 = '0;

        // Small instances: each source alone, then all five together.
        for (int i = 0; i < 5; i++) begin
            en5 = 5'(1 << i);
            tick();
            n_vec++;
            check($sformatf("n5 idx%0d c.sel", i), 32'(sel_c), 32'(i));
            check($sformatf("n5 idx%0d c.out", i), 32'(out_c), 32'(small_exp[i]));
            check($sformatf("n5 idx%0d d.sel", i), 32'(sel_d), 32'(i));
            check($sformatf("n5 idx%0d d.out", i), 32'(out_d), 32'(small_exp[i]));
            check($sformatf("n5 idx%0d c.cont", i), 32'(cont_c), 32'd0);
        end
        en5 = 5'h1F;
        tick();
        n_vec++;
        check("n5 all c.sel",  32'(sel_c),  32'd0);
        check("n5 all c.out",  32'(out_c),  32'h11);
        check("n5 all d.sel",  32'(sel_d),  32'd4);
        check("n5 all d.out",  32'(out_d),  32'h55);
        check("n5 all c.cont", 32'(cont_c), 32'd1);
        check("n5 all d.cnt",  32'(cnt_d),  32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
